// File: rtl/sensor_in_pkg.sv
// Shared types and defaults for the raw sensor-input conditioning blocks.
package sensor_in_pkg;

  // Debounce FSM: two settled levels plus one "checking" state per direction.
  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  // 1 ms at 50 MHz.
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_GLITCH_W      = 16;

endpackage : sensor_in_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input line.
// Shared by every sensor input so all lines see the same metastability margin.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Shift the raw line through two flops; only r_s2 is safe to consume.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule : sync_2ff

// File: rtl/sensor_in_debounce.sv
// Debounces one raw opto/limit-sensor line for the PIO input port.
// A new level must be seen on the synchronised line for STABLE_CYCLES
// consecutive clocks before it is accepted; shorter pulses are counted as
// glitches. All outputs come straight from flops.
module sensor_in_debounce
  import sensor_in_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int GLITCH_W      = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                glitch_clr,
  output logic                stable_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int                 CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  // With a one-cycle window a differing sample is accepted at once and the
  // CHK states are never entered.
  localparam bit                 SINGLE_CYC = (STABLE_CYCLES == 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
  localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

  logic                w_s2;
  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_stable_nxt;
  logic                w_rise_nxt;
  logic                w_fall_nxt;
  logic                w_glitch;
  logic [GLITCH_W-1:0] w_glitch_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (raw_in),
    .o_q   (w_s2)
  );

  // State register, stability counter and registered level/strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_LOW;
      r_cnt      <= '0;
      stable_out <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      stable_out <= w_stable_nxt;
      rise_pulse <= w_rise_nxt;
      fall_pulse <= w_fall_nxt;
    end
  end

  // Next state and counter: start a check on a level change, accept after a
  // full window, abort back to the settled state if the line reverts.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_LOW: begin
        if (w_s2) begin
          if (SINGLE_CYC) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_state_nxt = CHK_HIGH;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (!w_s2) begin
          w_state_nxt = ST_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
        end else begin
          // Only reached while r_cnt < STABLE_CYCLES-1, so it cannot wrap.
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!w_s2) begin
          if (SINGLE_CYC) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_state_nxt = CHK_LOW;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (w_s2) begin
          w_state_nxt = ST_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
      end
    endcase
  end

  // Output decode from the transition: accepted edges drive strobes, an
  // aborted check is a glitch; the level is high in ST_HIGH and CHK_LOW.
  always_comb begin
    w_stable_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == CHK_LOW);
    w_rise_nxt   = ((r_state == ST_LOW) || (r_state == CHK_HIGH)) &&
                   (w_state_nxt == ST_HIGH);
    w_fall_nxt   = ((r_state == ST_HIGH) || (r_state == CHK_LOW)) &&
                   (w_state_nxt == ST_LOW);
    w_glitch     = ((r_state == CHK_HIGH) && (w_state_nxt == ST_LOW)) ||
                   ((r_state == CHK_LOW)  && (w_state_nxt == ST_HIGH));
    if (glitch_clr) begin
      w_glitch_nxt = '0;
    end else if (w_glitch && (glitch_count != GLITCH_MAX)) begin
      w_glitch_nxt = glitch_count + GLITCH_ONE;
    end else begin
      w_glitch_nxt = glitch_count;
    end
  end

  // Saturating glitch counter; a clear in the same cycle as a glitch wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_count <= '0;
    end else begin
      glitch_count <= w_glitch_nxt;
    end
  end

endmodule : sensor_in_debounce
